// File: rtl/pistorm_bus_pkg.sv
// Shared state encoding, default window/timeout constants and address-decode helper
// for the 68k bus target.
package pistorm_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_REQ,
        ST_ACK,
        ST_BERR,
        ST_RELEASE
    } bus_state_t;

    localparam logic [23:0] DEFAULT_BASE_ADDR      = 24'hE90000;
    localparam logic [23:0] DEFAULT_ADDR_MASK      = 24'hFF0000;
    localparam logic [15:0] DEFAULT_TIMEOUT_CYCLES = 16'd4096;

    // A0 is implicit on the 68k bus, so the decoded byte address is {A[23:1], 0}.
    function automatic logic addr_hit(input logic [22:0] a,
                                      input logic [23:0] mask,
                                      input logic [23:0] base);
        return ((({a, 1'b0}) & mask) == base);
    endfunction

endpackage

// File: rtl/m68k_bus_target_sync_bit.sv
// Two-flop synchronizer for one asynchronous 68k strobe; resets to the negated level.
module SyncBit #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    (* async_reg = "true" *) logic [1:0] ff;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ff <= {2{RESET_VAL}};
        end else begin
            ff <= {ff[0], d};
        end
    end

    assign q = ff[1];

endmodule

// File: rtl/m68k_bus_target.sv
// 68k bus target: decodes an address window and forwards cycles to a Pi-side request port.
// Optional response watchdog enabled by defining M68K_TARGET_TIMEOUT_EN.
module m68k_bus_target
    import pistorm_bus_pkg::*;
#(
    parameter logic [23:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
    parameter logic [23:0] ADDR_MASK      = DEFAULT_ADDR_MASK,
    parameter logic [15:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        sys_clk,
    input  logic        nRESET,
    input  logic [23:1] A_IN,
    input  logic [15:0] D_IN,
    input  logic        nAS_IN,
    input  logic        nUDS_IN,
    input  logic        nLDS_IN,
    input  logic        RnW_IN,
    output logic [15:0] D_OUT,
    output logic        D_OE,
    output logic        nDTACK_OUT,
    output logic        nDTACK_OE,
    output logic        nBERR_OE,
    output logic        req_valid,
    output logic [23:0] req_addr,
    output logic        req_read,
    output logic [1:0]  req_be,
    output logic [15:0] req_wdata,
    input  logic        rsp_valid,
    input  logic [15:0] rsp_rdata,
    input  logic        rsp_err,
    output logic        busy
);

    logic nas_sync, nuds_sync, nlds_sync, rnw_sync;

    SyncBit #(.RESET_VAL(1'b1)) u_sync_as  (.clk(sys_clk), .rst_n(nRESET), .d(nAS_IN),  .q(nas_sync));
    SyncBit #(.RESET_VAL(1'b1)) u_sync_uds (.clk(sys_clk), .rst_n(nRESET), .d(nUDS_IN), .q(nuds_sync));
    SyncBit #(.RESET_VAL(1'b1)) u_sync_lds (.clk(sys_clk), .rst_n(nRESET), .d(nLDS_IN), .q(nlds_sync));
    SyncBit #(.RESET_VAL(1'b1)) u_sync_rnw (.clk(sys_clk), .rst_n(nRESET), .d(RnW_IN),  .q(rnw_sync));

    logic as_on, uds_on, lds_on;
    assign as_on  = !nas_sync;
    assign uds_on = !nuds_sync;
    assign lds_on = !nlds_sync;

    bus_state_t state;
    logic       aborted;    // master dropped AS while the Pi still owes a response
    logic       rel_drive;  // RELEASE actively drives DTACK high (hit path only)

`ifdef M68K_TARGET_TIMEOUT_EN
    logic [15:0] timeout_cnt;
`endif

    always_ff @(posedge sys_clk) begin
        if (!nRESET) begin
            state      <= ST_IDLE;
            aborted    <= 1'b0;
            rel_drive  <= 1'b0;
            busy       <= 1'b0;
            req_valid  <= 1'b0;
            req_addr   <= '0;
            req_read   <= 1'b0;
            req_be     <= '0;
            req_wdata  <= '0;
            D_OUT      <= '0;
            D_OE       <= 1'b0;
            nDTACK_OUT <= 1'b1;
            nDTACK_OE  <= 1'b0;
            nBERR_OE   <= 1'b0;
`ifdef M68K_TARGET_TIMEOUT_EN
            timeout_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (as_on) begin
                        state <= ST_DECODE;
                        busy  <= 1'b1;
                    end
                end

                ST_DECODE: begin
                    if (!as_on) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (!addr_hit(A_IN, ADDR_MASK, BASE_ADDR)) begin
                        state     <= ST_RELEASE;
                        rel_drive <= 1'b0;
                    end else if (uds_on || lds_on) begin
                        req_addr  <= {A_IN, 1'b0};
                        req_read  <= rnw_sync;
                        req_be    <= {uds_on, lds_on};
                        req_wdata <= D_IN;
                        req_valid <= 1'b1;
                        aborted   <= 1'b0;
                        state     <= ST_REQ;
`ifdef M68K_TARGET_TIMEOUT_EN
                        timeout_cnt <= '0;
`endif
                    end
                end

                ST_REQ: begin
`ifdef M68K_TARGET_TIMEOUT_EN
                    timeout_cnt <= timeout_cnt + 16'd1;
`endif
                    if (rsp_valid) begin
                        req_valid <= 1'b0;
                        if (aborted || !as_on) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else if (rsp_err) begin
                            state    <= ST_BERR;
                            nBERR_OE <= 1'b1;
                        end else begin
                            state      <= ST_ACK;
                            nDTACK_OE  <= 1'b1;
                            nDTACK_OUT <= 1'b0;
                            D_OE       <= req_read;
                            if (req_read) begin
                                D_OUT <= rsp_rdata;
                            end
                        end
                    end
`ifdef M68K_TARGET_TIMEOUT_EN
                    else if (timeout_cnt == TIMEOUT_CYCLES - 16'd1) begin
                        req_valid <= 1'b0;
                        if (aborted || !as_on) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state    <= ST_BERR;
                            nBERR_OE <= 1'b1;
                        end
                    end
`endif
                    else if (!as_on) begin
                        aborted <= 1'b1;
                    end
                end

                ST_ACK, ST_BERR: begin
                    if (!as_on) begin
                        state      <= ST_RELEASE;
                        rel_drive  <= 1'b1;
                        D_OE       <= 1'b0;
                        nBERR_OE   <= 1'b0;
                        nDTACK_OE  <= 1'b1;
                        nDTACK_OUT <= 1'b1;
                    end
                end

                ST_RELEASE: begin
                    // A window miss parks here silently until the master lets go of AS.
                    if (rel_drive || !as_on) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        nDTACK_OE <= 1'b0;
                        rel_drive <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m68k_bus_target.sv
// Directed bench for m68k_bus_target: read, write, miss, abort, bus error, reset, timeout.
module tb_m68k_bus_target;

`ifdef M68K_TARGET_TIMEOUT_EN
    localparam logic [15:0] TB_TIMEOUT = 16'd8;
`else
    localparam logic [15:0] TB_TIMEOUT = 16'd4096;
`endif

    logic        sys_clk = 1'b0;
    logic        nRESET;
    logic [23:1] A_IN;
    logic [15:0] D_IN;
    logic        nAS_IN, nUDS_IN, nLDS_IN, RnW_IN;
    logic [15:0] D_OUT;
    logic        D_OE, nDTACK_OUT, nDTACK_OE, nBERR_OE;
    logic        req_valid;
    logic [23:0] req_addr;
    logic        req_read;
    logic [1:0]  req_be;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    m68k_bus_target #(
        .BASE_ADDR(24'hE90000),
        .ADDR_MASK(24'hFF0000),
        .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .sys_clk(sys_clk), .nRESET(nRESET),
        .A_IN(A_IN), .D_IN(D_IN),
        .nAS_IN(nAS_IN), .nUDS_IN(nUDS_IN), .nLDS_IN(nLDS_IN), .RnW_IN(RnW_IN),
        .D_OUT(D_OUT), .D_OE(D_OE),
        .nDTACK_OUT(nDTACK_OUT), .nDTACK_OE(nDTACK_OE), .nBERR_OE(nBERR_OE),
        .req_valid(req_valid), .req_addr(req_addr), .req_read(req_read),
        .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0: return req_valid;
            1: return nDTACK_OUT;
            2: return busy;
            default: return nBERR_OE;
        endcase
    endfunction

    // Step negedges until the selected signal reaches val or the budget runs out.
    task automatic wait_sig(input string tag, input int sel, input logic val, input int limit);
        int k = 0;
        while (sig(sel) !== val && k < limit) begin
            @(negedge sys_clk);
            k++;
        end
        check(tag, {31'd0, sig(sel)}, {31'd0, val});
    endtask

    task automatic start_cycle(input logic [23:0] addr, input logic rnw,
                               input logic [1:0] be, input logic [15:0] wd);
        A_IN    = addr[23:1];
        RnW_IN  = rnw;
        D_IN    = wd;
        nAS_IN  = 1'b0;
        nUDS_IN = ~be[1];
        nLDS_IN = ~be[0];
    endtask

    task automatic end_cycle();
        nAS_IN  = 1'b1;
        nUDS_IN = 1'b1;
        nLDS_IN = 1'b1;
    endtask

    task automatic pulse_rsp(input logic [15:0] data, input logic err);
        rsp_valid = 1'b1;
        rsp_rdata = data;
        rsp_err   = err;
        @(negedge sys_clk);
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    initial begin
        logic seen_a, seen_b, seen_c;
        int   cnt;

        nRESET = 1'b0;
        A_IN = '0; D_IN = '0; RnW_IN = 1'b1;
        nAS_IN = 1'b1; nUDS_IN = 1'b1; nLDS_IN = 1'b1;
        rsp_valid = 1'b0; rsp_rdata = '0; rsp_err = 1'b0;
        idle(3);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_req_valid", {31'd0, req_valid}, 32'd0);
        check("rst_d_oe", {31'd0, D_OE}, 32'd0);
        check("rst_dtack_oe", {31'd0, nDTACK_OE}, 32'd0);
        check("rst_dtack_out", {31'd0, nDTACK_OUT}, 32'd1);
        check("rst_berr_oe", {31'd0, nBERR_OE}, 32'd0);
        check("rst_req_addr", {8'd0, req_addr}, 32'd0);
        nRESET = 1'b1;
        idle(2);

        // Word read at 0xE90010, Pi answers 5 cycles after the request appears.
        start_cycle(24'hE90010, 1'b1, 2'b11, 16'h0000);
        wait_sig("rd_req_valid", 0, 1'b1, 20);
        check("rd_req_addr", {8'd0, req_addr}, 32'h00E90010);
        check("rd_req_be", {30'd0, req_be}, 32'd3);
        check("rd_req_read", {31'd0, req_read}, 32'd1);
        check("rd_busy", {31'd0, busy}, 32'd1);
        idle(5);
        check("rd_req_hold", {31'd0, req_valid}, 32'd1);
        check("rd_addr_stable", {8'd0, req_addr}, 32'h00E90010);
        check("rd_no_early_dtack", {31'd0, nDTACK_OE}, 32'd0);
        pulse_rsp(16'hBEEF, 1'b0);
        check("rd_ack_dtack_oe", {31'd0, nDTACK_OE}, 32'd1);
        check("rd_ack_dtack", {31'd0, nDTACK_OUT}, 32'd0);
        check("rd_ack_d_oe", {31'd0, D_OE}, 32'd1);
        check("rd_ack_d_out", {16'd0, D_OUT}, 32'h0000BEEF);
        check("rd_req_drop", {31'd0, req_valid}, 32'd0);
        idle(4);
        check("rd_dtack_hold", {31'd0, nDTACK_OUT}, 32'd0);
        end_cycle();
        wait_sig("rd_release", 1, 1'b1, 10);
        check("rd_rel_dtack_oe", {31'd0, nDTACK_OE}, 32'd1);
        check("rd_rel_d_oe", {31'd0, D_OE}, 32'd0);
        idle(1);
        check("rd_rel_one_cycle", {31'd0, nDTACK_OE}, 32'd0);
        check("rd_idle_busy", {31'd0, busy}, 32'd0);
        idle(2);

        // Low-byte write at 0xE90003 (LDS only).
        start_cycle(24'hE90003, 1'b0, 2'b01, 16'h0055);
        wait_sig("wr_req_valid", 0, 1'b1, 20);
        check("wr_req_addr", {8'd0, req_addr}, 32'h00E90002);
        check("wr_req_read", {31'd0, req_read}, 32'd0);
        check("wr_req_be", {30'd0, req_be}, 32'd1);
        check("wr_req_wdata", {16'd0, req_wdata}, 32'h00000055);
        idle(2);
        pulse_rsp(16'h1234, 1'b0);
        check("wr_dtack", {31'd0, nDTACK_OUT}, 32'd0);
        check("wr_dtack_oe", {31'd0, nDTACK_OE}, 32'd1);
        check("wr_d_oe", {31'd0, D_OE}, 32'd0);
        end_cycle();
        wait_sig("wr_release", 2, 1'b0, 10);
        check("wr_d_oe_after", {31'd0, D_OE}, 32'd0);
        idle(2);

        // Access outside the window: 0xBFE001.
        start_cycle(24'hBFE001, 1'b1, 2'b01, 16'h0000);
        seen_a = 1'b0; seen_b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            seen_a |= req_valid;
            seen_b |= nDTACK_OE | D_OE | nBERR_OE;
        end
        check("miss_busy_held", {31'd0, busy}, 32'd1);
        end_cycle();
        for (int i = 0; i < 6; i++) begin
            @(negedge sys_clk);
            seen_a |= req_valid;
            seen_b |= nDTACK_OE | D_OE | nBERR_OE;
        end
        check("miss_no_req", {31'd0, seen_a}, 32'd0);
        check("miss_no_drive", {31'd0, seen_b}, 32'd0);
        check("miss_busy_clear", {31'd0, busy}, 32'd0);
        idle(2);

        // Aborted cycle: AS drops 2 cycles into REQ, Pi answers 10 cycles later.
        start_cycle(24'hE90020, 1'b1, 2'b11, 16'h0000);
        wait_sig("ab_req_valid", 0, 1'b1, 20);
        idle(2);
        end_cycle();
        seen_b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            seen_b |= nDTACK_OE | nBERR_OE | D_OE;
        end
        check("ab_req_still", {31'd0, req_valid}, 32'd1);
        check("ab_busy_still", {31'd0, busy}, 32'd1);
        pulse_rsp(16'hDEAD, 1'b0);
        seen_b |= nDTACK_OE | nBERR_OE | D_OE;
        check("ab_req_drop", {31'd0, req_valid}, 32'd0);
        check("ab_idle", {31'd0, busy}, 32'd0);
        idle(3);
        seen_b |= nDTACK_OE | nBERR_OE | D_OE;
        check("ab_no_drive", {31'd0, seen_b}, 32'd0);

        // Error response -> bus error until AS negation.
        start_cycle(24'hE90040, 1'b1, 2'b11, 16'h0000);
        wait_sig("be_req_valid", 0, 1'b1, 20);
        pulse_rsp(16'hFFFF, 1'b1);
        check("be_berr_oe", {31'd0, nBERR_OE}, 32'd1);
        check("be_d_oe", {31'd0, D_OE}, 32'd0);
        check("be_dtack_oe", {31'd0, nDTACK_OE}, 32'd0);
        idle(3);
        check("be_berr_hold", {31'd0, nBERR_OE}, 32'd1);
        end_cycle();
        wait_sig("be_berr_release", 3, 1'b0, 10);
        check("be_rel_dtack_oe", {31'd0, nDTACK_OE}, 32'd1);
        check("be_rel_dtack", {31'd0, nDTACK_OUT}, 32'd1);
        idle(1);
        check("be_idle", {31'd0, busy}, 32'd0);
        idle(1);

        // A stray response while idle changes nothing.
        pulse_rsp(16'h5A5A, 1'b0);
        idle(1);
        check("stray_busy", {31'd0, busy}, 32'd0);
        check("stray_dtack_oe", {31'd0, nDTACK_OE}, 32'd0);

        // Reset while DTACK is driven: released next cycle with no pulse.
        start_cycle(24'hE90010, 1'b1, 2'b11, 16'h0000);
        wait_sig("rsa_req_valid", 0, 1'b1, 20);
        pulse_rsp(16'hCAFE, 1'b0);
        check("rsa_in_ack", {31'd0, nDTACK_OE}, 32'd1);
        nRESET = 1'b0;
        @(negedge sys_clk);
        check("rsa_dtack_oe", {31'd0, nDTACK_OE}, 32'd0);
        check("rsa_d_oe", {31'd0, D_OE}, 32'd0);
        check("rsa_busy", {31'd0, busy}, 32'd0);
        end_cycle();
        idle(2);
        nRESET = 1'b1;
        idle(3);
        check("rsa_stays_off", {31'd0, nDTACK_OE}, 32'd0);

        // Reset in the middle of REQ.
        start_cycle(24'hE90010, 1'b1, 2'b11, 16'h0000);
        wait_sig("rsr_req_valid", 0, 1'b1, 20);
        nRESET = 1'b0;
        @(negedge sys_clk);
        check("rsr_req_valid", {31'd0, req_valid}, 32'd0);
        check("rsr_oes", {29'd0, D_OE, nDTACK_OE, nBERR_OE}, 32'd0);
        check("rsr_req_addr", {8'd0, req_addr}, 32'd0);
        end_cycle();
        idle(2);
        nRESET = 1'b1;
        idle(3);

`ifdef M68K_TARGET_TIMEOUT_EN
        // No response: watchdog forces a bus error after TB_TIMEOUT REQ cycles.
        start_cycle(24'hE90010, 1'b1, 2'b11, 16'h0000);
        wait_sig("to_req_valid", 0, 1'b1, 20);
        cnt = 0;
        while (nBERR_OE !== 1'b1 && cnt < 50) begin
            @(negedge sys_clk);
            cnt++;
        end
        check("to_cycles", cnt, 32'd8);
        check("to_berr_oe", {31'd0, nBERR_OE}, 32'd1);
        check("to_req_drop", {31'd0, req_valid}, 32'd0);
        end_cycle();
        wait_sig("to_release", 2, 1'b0, 10);
`else
        cnt = 0;
        seen_c = 1'b0;
        // Without the watchdog a request simply waits.
        start_cycle(24'hE90010, 1'b1, 2'b11, 16'h0000);
        wait_sig("nto_req_valid", 0, 1'b1, 20);
        while (cnt < 40) begin
            @(negedge sys_clk);
            seen_c |= nBERR_OE;
            cnt++;
        end
        check("nto_no_berr", {31'd0, seen_c}, 32'd0);
        check("nto_req_hold", {31'd0, req_valid}, 32'd1);
        pulse_rsp(16'h0001, 1'b0);
        check("nto_ack", {31'd0, nDTACK_OUT}, 32'd0);
        end_cycle();
        wait_sig("nto_release", 2, 1'b0, 10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
